// File: rtl/axil_pkg.sv
// Shared AXI-Lite definitions: response codes, the read-responder state
// encoding and a saturating counter helper.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LATCH = 2'd2,
        RESP  = 2'd3
    } r_resp_state_t;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/axil_addr_decode.sv
// Byte-address decoder for a word-addressed register bank: yields the
// register index plus misaligned and out-of-range flags.
module axil_addr_decode #(
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_REGS   = 16
) (
    input  logic [ADDR_WIDTH-1:0]       addr,
    output logic [$clog2(NUM_REGS)-1:0] index,
    output logic                        misaligned,
    output logic                        out_of_range
);

    localparam int WORD_W = ADDR_WIDTH - 2;

    logic [WORD_W-1:0] word_idx;

    // Split the byte address into word index and byte offset; the range
    // test uses one extra bit so NUM_REGS == 2^WORD_W stays representable.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path before any
        // condition is evaluated, so no latch can be inferred.
        word_idx     = addr[ADDR_WIDTH-1:2];
        index        = word_idx[$clog2(NUM_REGS)-1:0];
        misaligned   = (addr[1:0] != 2'b00);
        out_of_range = ({1'b0, word_idx} >= (WORD_W+1)'(NUM_REGS));
    end

endmodule

// File: rtl/axil_r_responder.sv
// AXI-Lite read responder: one outstanding read, fetched from a register
// file with a one-cycle read port, answered on the R channel with a
// response code and per-outcome saturating completion counters.
module axil_r_responder
    import axil_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_REGS   = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [ADDR_WIDTH-1:0]       araddr,
    input  logic                        arvalid,
    output logic                        arready,
    output logic [31:0]                 rdata,
    output logic [1:0]                  rresp,
    output logic                        rvalid,
    input  logic                        rready,
    output logic                        reg_rd_en,
    output logic [$clog2(NUM_REGS)-1:0] reg_rd_addr,
    input  logic [31:0]                 reg_rd_data,
    output logic [15:0]                 rd_count,
    output logic [15:0]                 err_count
);

    localparam int IDX_W = $clog2(NUM_REGS);

    r_resp_state_t state, state_next;

    logic [IDX_W-1:0] dec_index;
    logic             dec_misaligned;
    logic             dec_out_of_range;
    logic             dec_error;

    axil_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_decode (
        .addr         (araddr),
        .index        (dec_index),
        .misaligned   (dec_misaligned),
        .out_of_range (dec_out_of_range)
    );

    assign dec_error = dec_misaligned || dec_out_of_range;

    // State register; reset is synchronous, so it takes effect on the next edge.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; error addresses skip the fetch.
    always_comb begin
        state_next = state;
        arready    = 1'b0;
        rvalid     = 1'b0;
        reg_rd_en  = 1'b0;
        case (state)
            IDLE: begin
                arready = !reset;
                if (arvalid) begin
                    state_next = dec_error ? RESP : FETCH;
                end
            end
            FETCH: begin
                reg_rd_en  = 1'b1;
                state_next = LATCH;
            end
            LATCH: begin
                state_next = RESP;
            end
            RESP: begin
                rvalid = 1'b1;
                if (rready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Response payload, captured index and completion counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_rd_addr <= '0;
            rdata       <= '0;
            rresp       <= RESP_OKAY;
            rd_count    <= '0;
            err_count   <= '0;
        end else begin
            if (state == IDLE && arvalid) begin
                reg_rd_addr <= dec_index;
                if (dec_misaligned) begin
                    rdata <= '0;
                    rresp <= RESP_SLVERR;
                end else if (dec_out_of_range) begin
                    rdata <= '0;
                    rresp <= RESP_DECERR;
                end
            end
            if (state == LATCH) begin
                rdata <= reg_rd_data;
                rresp <= RESP_OKAY;
            end
            if (state == RESP && rready) begin
                if (rresp == RESP_OKAY) begin
                    rd_count <= sat_inc16(rd_count);
                end else begin
                    err_count <= sat_inc16(err_count);
                end
            end
        end
    end

endmodule

// File: tb/tb_axil_r_responder.sv
// Self-checking bench for axil_r_responder: a transaction-level latency
// model checked every cycle, plus directed scenarios with literal values.
module tb_axil_r_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        reg_rd_en;
    logic [3:0]  reg_rd_addr;
    logic [31:0] reg_rd_data;
    logic [15:0] rd_count;
    logic [15:0] err_count;

    int total = 0;
    int bad   = 0;

    axil_r_responder #(
        .ADDR_WIDTH (8),
        .NUM_REGS   (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .araddr      (araddr),
        .arvalid     (arvalid),
        .arready     (arready),
        .rdata       (rdata),
        .rresp       (rresp),
        .rvalid      (rvalid),
        .rready      (rready),
        .reg_rd_en   (reg_rd_en),
        .reg_rd_addr (reg_rd_addr),
        .reg_rd_data (reg_rd_data),
        .rd_count    (rd_count),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    // Register file behind the read port: data one cycle after the strobe.
    logic [31:0] regs [16];
    always @(posedge clk) begin
        if (reg_rd_en) reg_rd_data <= regs[reg_rd_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h, wanted %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic        chk_en = 1'b0;
    logic        busy   = 1'b0;
    int          t_ar   = 0;
    int          rdy_cyc = 0;
    logic        p_legal = 1'b0;
    logic [31:0] p_data = '0;
    logic [1:0]  p_resp = '0;
    logic [31:0] m_rdata = '0;
    logic [1:0]  m_rresp = '0;
    logic [15:0] m_rd = '0;
    logic [15:0] m_err = '0;
    logic [3:0]  p_idx = '0;
    logic        e_rvalid, e_arready, e_en;

    // Outputs are sampled on the falling edge; inputs change just after rising.
    always @(negedge clk) begin
        if (chk_en) begin
            e_rvalid  = busy && (cyc >= rdy_cyc);
            e_arready = !busy && !reset;
            e_en      = busy && p_legal && (cyc == t_ar + 1);
            if (busy && cyc == rdy_cyc) begin
                m_rdata = p_data;
                m_rresp = p_resp;
            end
            check("mon_arready",   32'(arready),   32'(e_arready));
            check("mon_rvalid",    32'(rvalid),    32'(e_rvalid));
            check("mon_reg_rd_en", 32'(reg_rd_en), 32'(e_en));
            if (e_en) check("mon_reg_rd_addr", 32'(reg_rd_addr), 32'(p_idx));
            check("mon_rdata",     rdata,          m_rdata);
            check("mon_rresp",     32'(rresp),     32'(m_rresp));
            check("mon_rd_count",  32'(rd_count),  32'(m_rd));
            check("mon_err_count", 32'(err_count), 32'(m_err));

            if (reset) begin
                busy = 1'b0; m_rd = '0; m_err = '0; m_rdata = '0; m_rresp = 2'b00;
            end else if (e_rvalid && rready) begin
                busy = 1'b0;
                if (m_rresp == 2'b00) begin
                    if (m_rd != 16'hFFFF) m_rd = m_rd + 16'd1;
                end else begin
                    if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
                end
            end else if (e_arready && arvalid) begin
                busy  = 1'b1;
                t_ar  = cyc;
                p_idx = 4'(araddr / 4);
                if (araddr % 4 != 0) begin
                    p_legal = 1'b0; p_resp = 2'b10; p_data = '0; rdy_cyc = cyc + 1;
                end else if (araddr / 4 >= 16) begin
                    p_legal = 1'b0; p_resp = 2'b11; p_data = '0; rdy_cyc = cyc + 1;
                end else begin
                    p_legal = 1'b1; p_resp = 2'b00; p_data = regs[araddr / 4]; rdy_cyc = cyc + 3;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Present an address and hold it until accepted; returns at T+1.
    task automatic do_ar(input logic [7:0] a);
        logic got = 1'b0;
        araddr  = a;
        arvalid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (arready) begin got = 1'b1; break; end
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL ar_timeout: address %02h never accepted", a);
        end
        tick();
        arvalid = 1'b0;
    endtask

    // Return on the falling edge of the first rvalid cycle.
    task automatic wait_rvalid();
        logic got = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (rvalid) begin got = 1'b1; break; end
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL rvalid_timeout: no response within 20 cycles");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) regs[i] = 32'h1000_0000 + 32'(i);
        regs[2] = 32'hDEAD_BEEF;
        regs[3] = 32'h1234_5678;
        reset = 1'b1; araddr = '0; arvalid = 1'b0; rready = 1'b1;
        tick(); tick();
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_rvalid",  32'(rvalid),  32'd0);
        check("rst_rdata",   rdata,        32'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("idle_arready", 32'(arready), 32'd1);
        tick();

        // Legal aligned read of reg[2], rready already high.
        do_ar(8'h08);
        @(negedge clk);
        check("legal_en_t1",   32'(reg_rd_en),   32'd1);
        check("legal_addr_t1", 32'(reg_rd_addr), 32'd2);
        @(negedge clk);
        check("legal_rvalid_t2", 32'(rvalid), 32'd0);
        @(negedge clk);
        check("legal_rvalid_t3", 32'(rvalid), 32'd1);
        check("legal_rdata",     rdata,       32'hDEAD_BEEF);
        check("legal_rresp",     32'(rresp),  32'd0);
        @(negedge clk);
        check("legal_rd_count",  32'(rd_count), 32'd1);
        check("legal_arready",   32'(arready),  32'd1);
        tick();

        // Misaligned read: SLVERR one cycle after the handshake.
        do_ar(8'h05);
        @(negedge clk);
        check("mis_rvalid", 32'(rvalid),    32'd1);
        check("mis_rresp",  32'(rresp),     32'd2);
        check("mis_rdata",  rdata,          32'd0);
        check("mis_en",     32'(reg_rd_en), 32'd0);
        @(negedge clk);
        check("mis_err_count", 32'(err_count), 32'd1);
        tick();

        // Out-of-range read: DECERR one cycle after the handshake.
        do_ar(8'h40);
        @(negedge clk);
        check("oor_rvalid", 32'(rvalid), 32'd1);
        check("oor_rresp",  32'(rresp),  32'd3);
        @(negedge clk);
        check("oor_err_count", 32'(err_count), 32'd2);
        tick();

        // Backpressure: response held five cycles while a new address waits.
        rready = 1'b0;
        do_ar(8'h04);
        tick(); tick();
        arvalid = 1'b1;
        araddr  = 8'h0C;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_rvalid",  32'(rvalid),  32'd1);
            check("bp_rdata",   rdata,        32'h1000_0001);
            check("bp_arready", 32'(arready), 32'd0);
            tick();
        end
        rready = 1'b1;
        @(negedge clk);
        check("bp_h_arready", 32'(arready), 32'd0);
        @(negedge clk);
        check("bp_h1_arready", 32'(arready), 32'd1);
        check("bp_h1_rvalid",  32'(rvalid),  32'd0);
        tick();
        arvalid = 1'b0;
        wait_rvalid();
        check("bp_second_rdata", rdata, 32'h1234_5678);
        @(negedge clk);
        check("bp_rd_count", 32'(rd_count), 32'd3);
        tick();

        // Reset while a response is pending.
        rready = 1'b0;
        do_ar(8'h08);
        wait_rvalid();
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("rr_arready_in_reset", 32'(arready), 32'd0);
        tick();
        @(negedge clk);
        check("rr_rvalid",    32'(rvalid),    32'd0);
        check("rr_rd_count",  32'(rd_count),  32'd0);
        check("rr_err_count", 32'(err_count), 32'd0);
        tick();
        reset  = 1'b0;
        rready = 1'b1;
        @(negedge clk);
        check("rr_arready_after", 32'(arready), 32'd1);
        tick();

        // Saturation: preload the OKAY counter just below its limit.
        force dut.rd_count = 16'hFFFE;
        m_rd = 16'hFFFE;
        #1 release dut.rd_count;
        do_ar(8'h00);
        wait_rvalid();
        @(negedge clk);
        check("sat_reach", 32'(rd_count), 32'h0000_FFFF);
        tick();
        do_ar(8'h00);
        wait_rvalid();
        @(negedge clk);
        check("sat_hold", 32'(rd_count), 32'h0000_FFFF);
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axil_r_responder.md
# axil_r_responder

Slave-side AXI-Lite read responder: accepts a read address on the AR channel, fetches one 32-bit word from a word-addressed register file through a one-cycle-latency read port, and returns it on the R channel with a response code. It is the subordinate-end counterpart of the master's R-channel receiver. It sits between the interconnect and a peripheral's register bank, one outstanding read at a time.

## Interface
- `ADDR_WIDTH`, 8: width of `araddr` in bits. Byte address.
- `NUM_REGS`, 16: number of 32-bit registers implemented, valid indices 0..NUM_REGS-1. Must satisfy NUM_REGS ≤ 2^(ADDR_WIDTH-2).
- `clk` in 1: single clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `araddr` in ADDR_WIDTH: read byte address.
- `arvalid` in 1: address valid.
- `arready` out 1: address accepted when high together with `arvalid`.
- `rdata` out 32: read data.
- `rresp` out 2: 00 OKAY, 10 SLVERR, 11 DECERR.
- `rvalid` out 1: read response valid.
- `rready` in 1: master accepts the response.
- `reg_rd_en` out 1: one-cycle read strobe to the register file.
- `reg_rd_addr` out $clog2(NUM_REGS): register index.
- `reg_rd_data` in 32: register contents, valid the cycle after `reg_rd_en`.
- `rd_count` out 16: count of completed OKAY responses, saturating at 0xFFFF.
- `err_count` out 16: count of completed error responses, saturating at 0xFFFF.

## Operation
- The state machine has four states: IDLE, FETCH, LATCH and RESP. It resets to IDLE.
- Reset values:
  - `rvalid`=0, `rdata`=0, `rresp`=00, `reg_rd_en`=0, `reg_rd_addr`=0, counters 0.
  - `arready` is forced to 0 while `reset` is high.
- `arready` = (state==IDLE) && !reset. It is high in no other state.
- IDLE, on `arvalid && arready`:
  - Capture `araddr`.
  - Index = araddr[ADDR_WIDTH-1:2].
  - If araddr[1:0] != 0, go to RESP with `rresp`=10 and `rdata`=0.
  - Else if index ≥ NUM_REGS, go to RESP with `rresp`=11 and `rdata`=0.
  - Otherwise go to FETCH.
- FETCH: `reg_rd_en`=1 and `reg_rd_addr`=index, for exactly one cycle. Then go to LATCH.
- LATCH: register `reg_rd_data` into `rdata`, set `rresp`=00 and go to RESP.
- RESP:
  - `rvalid`=1. `rdata` and `rresp` are held stable until `rvalid && rready`.
  - On the handshake, go to IDLE, `rvalid` falls the next cycle, and `rd_count` or `err_count` increments according to `rresp`.
- `rdata` and `rresp` keep their last value after the handshake until the next response is loaded.
- Register-file reads happen only for legal, aligned addresses. Error paths never assert `reg_rd_en`.
- Reset in any state returns to IDLE on the next edge. An in-flight transaction is dropped and no counter increments.

## Timing
- AR handshake at cycle T.
- Legal read:
  - `reg_rd_en` high at T+1.
  - `reg_rd_data` sampled at T+2.
  - `rvalid` first high at T+3.
- Error read: `rvalid` first high at T+1.
- Handshake at cycle H (`rvalid && rready`):
  - `rvalid`=0 and `arready`=1 at H+1.
  - The counter update is visible at H+1.
- A new AR may handshake at H+1. Minimum legal-read period is 4 cycles.
- `rready` held high before `rvalid` is legal. The handshake then occurs in the first `rvalid` cycle.
- `arvalid` asserted outside IDLE is ignored until `arready` rises. `araddr` is sampled only on the AR handshake.
- Counters saturate: at 0xFFFF, a further completion leaves the value at 0xFFFF.

## Structure
- Shared package `axil_pkg` holds:
  - response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - `r_resp_state_t` enum {IDLE, FETCH, LATCH, RESP}.
- One sub-module: `axil_addr_decode` (combinational). It takes the byte address and returns the index, a misaligned flag and an out-of-range flag. It is parameterised by ADDR_WIDTH and NUM_REGS.

## Test plan
- **Legal read.** After reset, araddr=0x08, reg[2]=0xDEADBEEF, rready held high:
  - `reg_rd_en` at T+1 with `reg_rd_addr`=2;
  - `rvalid` at T+3 with `rdata`=0xDEADBEEF and `rresp`=00;
  - `rd_count`=1.
- **Misaligned read.** araddr=0x05 → `rvalid` at T+1, `rresp`=10, `rdata`=0, `reg_rd_en` never high, `err_count`=1.
- **Out-of-range read.** NUM_REGS=16, araddr=0x40 → `rresp`=11 at T+1 and no register read.
- **Backpressure.** rready low for 5 cycles after `rvalid` → `rdata` and `rresp` stable, `arready`=0 throughout, and `arvalid` with araddr=0x0C during the stall is not accepted until H+1.
- **Reset mid-RESP.** Reset pulsed while `rvalid`=1 → next cycle `rvalid`=0, `arready`=0 during reset and 1 after it, counters 0.
- **Saturation.** Preload via 65535 OKAY reads (or force), then one more read → `rd_count` stays 0xFFFF.
